// File: rtl/reg_arb_pkg.sv
// ============================================================================
// reg_arb_pkg : shared widths, register count and arbiter FSM state type
// Rev 1.0
// ============================================================================
`default_nettype none

package reg_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CLEAR = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : two-way request picker; round-robin when REG_ARB_RR_EN is
//           defined, fixed A-over-B priority otherwise
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic CLK,
  input  logic RESET,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_adv,
  output logic o_gnt_a,
  output logic o_gnt_b
);

`ifdef REG_ARB_RR_EN
  // r_prio_b set means B wins the next tie
  logic r_prio_b;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_prio_b <= 1'b0;
    end else if (i_adv && (o_gnt_a || o_gnt_b)) begin
      r_prio_b <= o_gnt_a;
    end
  end

  always_comb begin
    o_gnt_a = i_req_a && (!i_req_b || !r_prio_b);
    o_gnt_b = i_req_b && (!i_req_a ||  r_prio_b);
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, CLK, RESET, i_adv};
  assign o_gnt_a  = i_req_a;
  assign o_gnt_b  = i_req_b && !i_req_a;
`endif

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// ============================================================================
// reg_write_arbiter : arbitrates ALU/load writebacks and a register-file
//                     clear onto one registered write port.
//                     Build option: REG_ARB_RR_EN selects round-robin A/B.
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              A_REQ,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DATA,
  output logic              A_ACK,
  input  logic              B_REQ,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DATA,
  output logic              B_ACK,
  input  logic              CLR_REQ,
  output logic              CLR_BUSY,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] IN
);

  arb_state_t        r_state,   w_nxt_state;
  logic [ADDR_W-1:0] r_clr_cnt, w_nxt_clr_cnt;
  logic              r_write,   w_nxt_write;
  logic [ADDR_W-1:0] r_addr,    w_nxt_addr;
  logic [DATA_W-1:0] r_data,    w_nxt_data;
  logic              r_a_ack,   w_nxt_a_ack;
  logic              r_b_ack,   w_nxt_b_ack;
  logic              r_busy,    w_nxt_busy;

  logic w_elig_a, w_elig_b, w_gnt_a, w_gnt_b, w_adv, w_clear_run;

  // A requester whose ACK is on the wire right now has just finished
  assign w_elig_a = A_REQ && !r_a_ack;
  assign w_elig_b = B_REQ && !r_b_ack;

  rr_arb2 u_pick (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_req_a (w_elig_a),
    .i_req_b (w_elig_b),
    .i_adv   (w_adv),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b)
  );

  assign w_clear_run = (r_state == CLEAR) && (r_clr_cnt != '1);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_clr_cnt = r_clr_cnt;
    w_nxt_write   = 1'b0;
    w_nxt_addr    = r_addr;
    w_nxt_data    = r_data;
    w_nxt_a_ack   = 1'b0;
    w_nxt_b_ack   = 1'b0;
    w_nxt_busy    = 1'b0;
    w_adv         = 1'b0;

    if (w_clear_run) begin
      w_nxt_clr_cnt = r_clr_cnt + 1'b1;
      w_nxt_write   = 1'b1;
      w_nxt_addr    = r_clr_cnt + 1'b1;
      w_nxt_data    = '0;
      w_nxt_busy    = 1'b1;
    end else if ((r_state != CLEAR) && CLR_REQ) begin
      w_nxt_state   = CLEAR;
      w_nxt_clr_cnt = '0;
      w_nxt_write   = 1'b1;
      w_nxt_addr    = '0;
      w_nxt_data    = '0;
      w_nxt_busy    = 1'b1;
    end else if (w_gnt_a || w_gnt_b) begin
      // Also reached on the last clear write: pending requests go next cycle
      w_nxt_state = GRANT;
      w_adv       = 1'b1;
      w_nxt_write = 1'b1;
      w_nxt_a_ack = w_gnt_a;
      w_nxt_b_ack = w_gnt_b;
      w_nxt_addr  = w_gnt_a ? A_ADDR : B_ADDR;
      w_nxt_data  = w_gnt_a ? A_DATA : B_DATA;
    end else begin
      w_nxt_state = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_clr_cnt <= '0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_clr_cnt <= w_nxt_clr_cnt;
      r_write   <= w_nxt_write;
      r_addr    <= w_nxt_addr;
      r_data    <= w_nxt_data;
      r_a_ack   <= w_nxt_a_ack;
      r_b_ack   <= w_nxt_b_ack;
      r_busy    <= w_nxt_busy;
    end
  end

  assign WRITE     = r_write;
  assign INADDRESS = r_addr;
  assign IN        = r_data;
  assign A_ACK     = r_a_ack;
  assign B_ACK     = r_b_ack;
  assign CLR_BUSY  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ============================================================================
// tb_reg_write_arbiter : directed bench with a cycle-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          A_REQ = 1'b0, B_REQ = 1'b0, CLR_REQ = 1'b0;
  logic [AW-1:0] A_ADDR = '0, B_ADDR = '0;
  logic [DW-1:0] A_DATA = '0, B_DATA = '0;
  logic          A_ACK, B_ACK, CLR_BUSY, WRITE;
  logic [AW-1:0] INADDRESS;
  logic [DW-1:0] IN;

  int n_checks = 0;
  int n_errors = 0;

  reg_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET),
    .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_ACK(A_ACK),
    .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_ACK(B_ACK),
    .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY),
    .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending clear writes counted down, plain tie-break rules
  bit            m_valid = 1'b0;
  bit            m_write, m_a_ack, m_b_ack, m_busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_clr_left;
  int            m_last;

  always @(posedge CLK) begin : model
    bit ea, eb, ga, gb, was_busy;
    if (RESET) begin
      m_valid = 1'b1; m_write = 0; m_a_ack = 0; m_b_ack = 0; m_busy = 0;
      m_addr = '0; m_data = '0; m_clr_left = 0; m_last = "B";
    end else if (m_valid) begin
      ea = A_REQ && !m_a_ack;
      eb = B_REQ && !m_b_ack;
      was_busy = m_busy;
      m_write = 0; m_a_ack = 0; m_b_ack = 0; m_busy = 0;
      if (was_busy && m_clr_left > 0) begin
        m_addr = AW'(NUM_REGS - m_clr_left);
        m_data = '0; m_write = 1; m_busy = 1;
        m_clr_left--;
      end else if (CLR_REQ && !was_busy) begin
        m_addr = '0; m_data = '0; m_write = 1; m_busy = 1;
        m_clr_left = NUM_REGS - 1;
      end else begin
`ifdef REG_ARB_RR_EN
        if (ea && eb) begin
          ga = (m_last == "B");
          gb = !ga;
        end else begin
          ga = ea; gb = eb;
        end
`else
        ga = ea;
        gb = eb && !ea;
`endif
        if (ga) begin
          m_a_ack = 1; m_write = 1; m_addr = A_ADDR; m_data = A_DATA; m_last = "A";
        end else if (gb) begin
          m_b_ack = 1; m_write = 1; m_addr = B_ADDR; m_data = B_DATA; m_last = "B";
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("WRITE", WRITE, m_write);
      chk("INADDRESS", INADDRESS, m_addr);
      chk("IN", IN, m_data);
      chk("A_ACK", A_ACK, m_a_ack);
      chk("B_ACK", B_ACK, m_b_ack);
      chk("CLR_BUSY", CLR_BUSY, m_busy);
      chk("ACK_EXCL", A_ACK & B_ACK, 0);
    end
  end

  task automatic chk_outs(input string nm, input int w, input int ad, input int d,
                          input int aa, input int ba, input int bz);
    chk({nm, ".WRITE"}, WRITE, w);
    chk({nm, ".INADDRESS"}, INADDRESS, ad);
    chk({nm, ".IN"}, IN, d);
    chk({nm, ".A_ACK"}, A_ACK, aa);
    chk({nm, ".B_ACK"}, B_ACK, ba);
    chk({nm, ".CLR_BUSY"}, CLR_BUSY, bz);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nw;
    repeat (2) @(negedge CLK);
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    RESET = 1'b0;

    // single A write, one cycle latency, outputs hold afterwards
    A_REQ = 1; A_ADDR = 3'b010; A_DATA = 8'h1F;
    @(negedge CLK);
    chk_outs("a_single", 1, 2, 8'h1F, 1, 0, 0);
    A_REQ = 0;
    @(negedge CLK);
    chk_outs("a_hold", 0, 2, 8'h1F, 0, 0, 0);

    // both requesters continuous from a fresh reset
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    A_REQ = 1; A_ADDR = 3'd4; A_DATA = 8'h55;
    B_REQ = 1; B_ADDR = 3'd5; B_DATA = 8'hAA;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (i % 2 == 0) chk_outs("alt_a", 1, 4, 8'h55, 1, 0, 0);
      else            chk_outs("alt_b", 1, 5, 8'hAA, 0, 1, 0);
    end
    // clear taken out of GRANT while both keep requesting
    CLR_REQ = 1;
    @(negedge CLK);
    CLR_REQ = 0;
    repeat (11) @(negedge CLK);
    // reset in the middle of a grant stream
    RESET = 1;
    @(negedge CLK);
    RESET = 0; A_REQ = 0; B_REQ = 0;
    chk_outs("rst_grant", 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge CLK);

    // clear wins over a simultaneous A request
    A_REQ = 1; A_ADDR = 3'd6; A_DATA = 8'h3C; CLR_REQ = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == 0) CLR_REQ = 0;
      chk_outs("clr_seq", 1, i, 0, 0, 0, 1);
    end
    @(negedge CLK);
    chk_outs("clr_then_a", 1, 6, 8'h3C, 1, 0, 0);
    A_REQ = 0;
    repeat (2) @(negedge CLK);

    // reset during the fourth clear write
    CLR_REQ = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (i == 0) CLR_REQ = 0;
    end
    chk_outs("clr_addr3", 1, 3, 0, 0, 0, 1);
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    chk_outs("clr_abort", 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk_outs("clr_abort2", 0, 0, 0, 0, 0, 0);

    // CLR_REQ held: eight writes, one idle cycle, then a second clear
    CLR_REQ = 1;
    nw = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge CLK);
      nw += int'(WRITE);
    end
    chk("held_clr_writes", nw, 8);
    chk_outs("held_clr_gap", 0, 7, 0, 0, 0, 0);
    @(negedge CLK);
    chk_outs("held_clr_again", 1, 0, 0, 0, 0, 1);
    CLR_REQ = 0;
    repeat (9) @(negedge CLK);
    chk("held_clr_done", CLR_BUSY, 0);

    // protocol-following requesters with occasional clears
    for (int c = 0; c < 80; c++) begin
      if (m_a_ack || !A_REQ) begin
        A_REQ = 1'($urandom_range(0, 1));
        A_ADDR = AW'($urandom_range(0, 7));
        A_DATA = DW'($urandom_range(0, 255));
      end
      if (m_b_ack || !B_REQ) begin
        B_REQ = 1'($urandom_range(0, 1));
        B_ADDR = AW'($urandom_range(0, 7));
        B_DATA = DW'($urandom_range(0, 255));
      end
      CLR_REQ = ($urandom_range(0, 15) == 0);
      @(negedge CLK);
    end
    A_REQ = 0; B_REQ = 0; CLR_REQ = 0;
    repeat (12) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, register data width.
REQ-002 Parameter ADDR_W, default 3, register address width; NUM_REGS = 2**ADDR_W = 8.
REQ-003 CLK  in  1  clock; all state updates on rising edge.
REQ-004 RESET  in  1  reset, synchronous, active-high.
REQ-005 A_REQ  in  1  requester A (ALU writeback) write request.
REQ-006 A_ADDR  in  ADDR_W  requester A destination register.
REQ-007 A_DATA  in  DATA_W  requester A write data.
REQ-008 A_ACK  out  1  one-cycle grant pulse to A.
REQ-009 B_REQ / B_ADDR / B_DATA / B_ACK  in/in/in/out  1/ADDR_W/DATA_W/1  same as A, for requester B (memory load).
REQ-010 CLR_REQ  in  1  request to zero all registers.
REQ-011 CLR_BUSY  out  1  clear sequence in progress.
REQ-012 WRITE  out  1  register-file write enable.
REQ-013 INADDRESS  out  ADDR_W  register-file write address.
REQ-014 IN  out  DATA_W  register-file write data.

Function
REQ-015 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-016 A requester SHALL hold REQ, ADDR and DATA stable until it sees ACK high; the handshake completes in the cycle ACK is high.
REQ-017 At each edge, requester X is eligible iff X_REQ=1 and X_ACK=0; a requester SHALL NOT be granted in two consecutive cycles.
REQ-018 A grant SHALL, in the following cycle, drive WRITE=1, INADDRESS=X_ADDR, IN=X_DATA and X_ACK=1 for exactly one cycle; latency request-to-write is one cycle.
REQ-019 At most one of A_ACK, B_ACK SHALL be high in any cycle; WRITE=1 iff an ACK is high or a clear write is issued.
REQ-020 When WRITE=0, INADDRESS and IN SHALL hold their previous values.
REQ-021 FSM states: IDLE, GRANT, CLEAR. IDLE→GRANT on any eligible request; GRANT→GRANT on a further eligible request, else →IDLE; IDLE/GRANT→CLEAR on CLR_REQ; CLEAR→IDLE after last clear write.
REQ-022 CLR_REQ SHALL have priority over A and B; with CLR_REQ and an eligible request on the same edge, the clear is taken and the request waits.
REQ-023 CLEAR SHALL issue 8 consecutive writes, IN=0, INADDRESS=0..7 ascending, one per cycle, starting the cycle after CLR_REQ is sampled.
REQ-024 CLR_BUSY SHALL be high in exactly the 8 clear-write cycles.
REQ-025 CLR_REQ while in CLEAR SHALL be ignored; A/B requests pending during CLEAR SHALL NOT be acked until the cycle after the last clear write.
REQ-026 Clear counter SHALL be 3 bits and SHALL stop at 7; it does not wrap into a ninth write.

Reset
REQ-027 RESET SHALL force: WRITE=0, INADDRESS=0, IN=0, A_ACK=0, B_ACK=0, CLR_BUSY=0, state IDLE, clear counter 0, round-robin pointer favouring A.
REQ-028 RESET during CLEAR or GRANT SHALL abort immediately; no write issues in the cycle after RESET is sampled.
REQ-029 RESET SHALL take priority over every request sampled on the same edge.

Configuration
REQ-030 Macro REG_ARB_RR_EN: defined → A/B arbitration is round-robin; after a grant to X, the other requester has priority on the next contention.
REQ-031 REG_ARB_RR_EN undefined → fixed priority, A over B; the REQ-017 rule alone keeps B from starving under continuous A requests.
REQ-032 Clear priority (REQ-022) SHALL be identical in both builds.

Structure
REQ-033 Package reg_arb_pkg SHALL hold DATA_W/ADDR_W defaults, NUM_REGS, and the FSM state typedef (IDLE, GRANT, CLEAR).
REQ-034 A sub-module rr_arb2 (2-way picker with priority pointer, pointer logic compiled out when REG_ARB_RR_EN is undefined) SHALL perform the A/B selection.

Verification
REQ-035 A_REQ=1, A_ADDR=3'b010, A_DATA=8'h1F at edge t → at t+1: WRITE=1, INADDRESS=2, IN=8'h1F, A_ACK=1; at t+2: WRITE=0.
REQ-036 A and B both request continuously (A→reg4/8'h55, B→reg5/8'hAA), RR build → ACKs alternate A,B,A,B from the first grant; WRITE high every cycle.
REQ-037 Same stimulus, fixed-priority build → first grant A, then B, then A (REQ-017), no cycle without WRITE.
REQ-038 CLR_REQ pulse with A_REQ high on same edge → 8 cycles WRITE=1, IN=0, INADDRESS 0..7, CLR_BUSY=1; A_ACK in the 9th cycle.
REQ-039 RESET asserted during the 4th clear write (INADDRESS=3) → next cycle WRITE=0, CLR_BUSY=0, all outputs at reset values.
REQ-040 CLR_REQ held high throughout a clear → exactly 8 writes; a second clear starts only if CLR_REQ is still high when the FSM is in IDLE.
